// File: rtl/lcd_frame_scheduler.sv
// Character LCD frame scheduler: en_clk divider, front/back text buffers with tear-free swap,
// and a round-robin write arbiter for two text sources. Optional macro: LCD_FRAME_SCHEDULER_BLANK_EN.
module lcd_frame_scheduler #(
  parameter int TICK_DIV = 2500000,
  parameter int CHARS    = 32
) (
`ifdef LCD_FRAME_SCHEDULER_BLANK_EN
  input  logic       blank,
`endif
  input  logic       clk,
  input  logic       rst,
  output logic       en_clk,
  input  logic [4:0] index_char,
  output logic [7:0] data_char,
  input  logic       a_req,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_gnt,
  input  logic       commit,
  output logic       swap_pending,
  output logic       frame_done
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic [DIV_W-1:0] div;
  logic [7:0]       front [CHARS];
  logic [7:0]       back  [CHARS];
  logic             rr;
  logic             contested;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             swap;

  // rr=0 favours A on the next contested cycle, rr=1 favours B
  always_comb begin
    contested = a_req & b_req;
    a_gnt     = a_req & (~b_req | ~rr);
    b_gnt     = b_req & (~a_req | rr);
    wr_en     = a_gnt | b_gnt;
    wr_addr   = a_gnt ? a_addr : b_addr;
    wr_data   = a_gnt ? a_data : b_data;
    swap      = swap_pending & en_clk & (index_char == 5'(CHARS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= '0;
      en_clk       <= 1'b0;
      swap_pending <= 1'b0;
      frame_done   <= 1'b0;
      rr           <= 1'b0;
      for (int i = 0; i < CHARS; i++) begin
        front[i] <= 8'h20;
        back[i]  <= 8'h20;
      end
    end else begin
      div    <= (div == DIV_W'(TICK_DIV - 1)) ? '0 : div + DIV_W'(1);
      en_clk <= (div == DIV_W'(TICK_DIV - 1));
      if (contested)
        rr <= ~rr;
      // a fresh commit on the swap edge keeps the request armed for the next frame
      swap_pending <= commit | (swap_pending & ~swap);
      frame_done   <= swap;
      // front copies back as it was before this edge's write lands
      if (swap)
        for (int i = 0; i < CHARS; i++)
          front[i] <= back[i];
      if (wr_en)
        back[wr_addr] <= wr_data;
    end
  end

`ifdef LCD_FRAME_SCHEDULER_BLANK_EN
  assign data_char = blank ? 8'h20 : front[index_char];
`else
  assign data_char = front[index_char];
`endif

endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
- Sequences the character LCD driver and shares it between two text sources.
- Generates the driver's `en_clk` strobe from a programmable divider.
- Serves `data_char` for the driver's `index_char` from a 32-byte front buffer.
- Two requesters (clock/time formatter = A, menu/alarm UI = B) write a back buffer through a round-robin arbiter. A commit copies back to front only at a frame boundary, so the display never tears.

Parameters:
- TICK_DIV, 2500000, `clk` cycles per `en_clk` pulse (50 ms at 50 MHz); legal range 2..2^22.
- CHARS, 32, buffer depth; fixed to match the 5-bit `index_char`.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- en_clk  output  1  one-cycle step strobe to LCD driver
- index_char  input  5  character index from LCD driver
- data_char  output  8  character code for `index_char`
- a_req  input  1  requester A write request
- a_addr  input  5  requester A character position
- a_data  input  8  requester A character code
- a_gnt  output  1  requester A write accepted this cycle
- b_req  input  1  requester B write request
- b_addr  input  5  requester B character position
- b_data  input  8  requester B character code
- b_gnt  output  1  requester B write accepted this cycle
- commit  input  1  pulse: publish back buffer to front
- swap_pending  output  1  commit accepted, swap not yet done
- frame_done  output  1  one-cycle pulse the cycle after a swap

Interface: one clock; reset is synchronous and active-high. Ports are named `clk` and `rst`.

Behaviour:
- Reset (`rst`=1 at a `clk` edge):
  - divider=0, `en_clk`=0.
  - All 32 front and 32 back entries = 8'h20 (space).
  - `swap_pending`=0, `frame_done`=0, round-robin pointer=A.
  - Reset mid-frame or mid-swap discards all pending writes and commits.
- Divider:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `en_clk` is registered and high exactly one cycle when the count equals TICK_DIV-1. Period = TICK_DIV cycles.
  - Free-running; no gating.
- Read path: `data_char` = front[`index_char`], combinational, zero latency.
- Arbiter (combinational grants, at most one write per cycle):
  - Only one requesting: that requester is granted.
  - Both requesting: grant the side the pointer selects. The pointer flips to the other side after every contested grant.
  - Uncontested grants leave the pointer unchanged.
  - A granted write lands in back[addr] at that edge.
  - A requester holds req/addr/data stable until it sees its gnt.
  - Gnt is never asserted without req.
- Commit / swap:
  - `commit`=1 sets `swap_pending` at the next edge. Commit while already pending is absorbed.
  - Swap edge = the edge where `swap_pending`=1, `en_clk`=1 and `index_char`==31 (last character of frame being stepped).
  - At the swap edge: front <= back (all 32 entries, one cycle), `swap_pending` <= 0, `frame_done` <= 1 for the following cycle.
  - A write granted on the swap edge updates back only. Front receives the pre-write back contents.
  - `commit` asserted on the swap edge re-arms `swap_pending` (pending wins over clear).
  - `data_char` for index 31 on the swap edge is the old front value.
- Back buffer persists across swaps. Requesters may update only changed positions (e.g. seconds digits).

Optional Feature:
- Macro: LCD_FRAME_SCHEDULER_BLANK_EN.
- With it defined: adds input port `blank` (1 bit). While `blank`=1, `data_char` is forced to 8'h20 and buffers are unaffected. Writes, commit and swap operate normally.
- Without it: no `blank` port, and `data_char` is always front[`index_char`].

Test Plan:
- Reset then idle, TICK_DIV=4 → `en_clk` high on cycles 4, 8, 12 after reset release. `data_char`=8'h20 for all `index_char` 0..31. `swap_pending`=0.
- A writes addr 3 = 8'h31, then commit, then `index_char` stepped to 31 with `en_clk` → `swap_pending` goes 1 and clears on the swap edge. `frame_done` pulses once. Afterwards `index_char`=3 gives 8'h31. Before the swap, `data_char`@3 = 8'h20.
- A and B both requesting for 4 cycles (A: addr 0 data 8'h41; B: addr 1 data 8'h42, each re-requesting) → grants A,B,A,B. Never both gnt the same cycle. Back[0]=8'h41, back[1]=8'h42.
- B write to addr 5 = 8'h35 granted on the swap edge → front[5] keeps its old value, back[5]=8'h35. A second commit plus swap publishes 8'h35.
- Commit pulse on the swap edge → `swap_pending` is 1 after that edge, and the next frame boundary performs a second swap.
- `rst` asserted while `swap_pending`=1 with `index_char`=20 → all outputs return to reset values. The buffer reads 8'h20 everywhere. No `frame_done` pulse follows.
